alu_seq: RTL and testbench

Parametrised multi-cycle ALU, next generation of the processor's 16-bit single-cycle ALU. Keeps the original six operation encodings, widens the datapath to WIDTH bits, and adds shifts, unsigned compare, and iterative multiply/divide. A valid/ready handshake on both sides lets the control unit stall while long operations run. Full NZCV-style flags are produced alongside the result.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_seq_if.sv | 31 +++
 rtl/alu_muldiv_seq.sv | 98 +++++++++
 rtl/alu_seq.sv | 140 ++++++++++++++
 tb/tb_alu_seq.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the alu_seq multi-cycle ALU: opcodes, FSM states and the NZCV flag bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_SLT   = 4'd4,
    OP_LUI   = 4'd5,
    OP_XOR   = 4'd6,
    OP_SLTU  = 4'd7,
    OP_SLL   = 4'd8,
    OP_SRL   = 4'd9,
    OP_SRA   = 4'd10,
    OP_MUL   = 4'd11,
    OP_MULHU = 4'd12,
    OP_DIVU  = 4'd13,
    OP_REMU  = 4'd14,
    OP_RSVD  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

  function automatic logic is_muldiv(alu_op_e op);
    return op inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU};
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit (master) and alu_seq (slave).
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  import alu_pkg::*;

  logic             in_valid;
  logic             in_ready;
  alu_op_e          op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;
  logic             illegal;

  modport master (
    output in_valid, op, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, zero, negative, carry, overflow, illegal
  );

  modport slave (
    input  in_valid, op, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, zero, negative, carry, overflow, illegal
  );

endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative unit for MUL/MULHU (radix-2 shift-add) and DIVU/REMU (restoring), one bit per cycle.
// Only instantiated when ALU_MULDIV_EN is defined.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic             active_q, active_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  alu_op_e          op_q, op_d;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] step_hi, step_lo;

  // hi:lo is the running product for multiply and the remainder:dividend pair for divide.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    active_d = active_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    b_d      = b_q;
    op_d     = op_q;
    done     = 1'b0;

    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};

    if (op_q inside {OP_DIVU, OP_REMU}) begin
      // A borrow out of diff means the divisor does not fit: restore and shift in a 0.
      step_hi = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
    end else begin
      step_hi = add_sum[WIDTH:1];
      step_lo = {add_sum[0], lo_q[WIDTH-1:1]};
    end

    if (active_q) begin
      hi_d = step_hi;
      lo_d = step_lo;
      if (cnt_q == CW'(WIDTH - 1)) begin
        active_d = 1'b0;
        done     = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      hi_d     = '0;
      lo_d     = a;
      b_d      = b;
      op_d     = op;
    end

    result = (op_q inside {OP_MUL, OP_DIVU}) ? step_lo : step_hi;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      op_q     <= op_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle WIDTH-bit ALU with valid/ready handshakes and registered NZCV flags.
// Define ALU_MULDIV_EN to build MUL/MULHU/DIVU/REMU; otherwise those opcodes report illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic    clk,
  input  logic    reset,
  alu_seq_if.slave bus
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int HALF = WIDTH / 2;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             long_op;
  logic [WIDTH-1:0] a, b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum_w, dif_w;
  logic [WIDTH-1:0] simple_res;
  logic             simple_c, simple_v, simple_ill;

  assign bus.in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = flags_q.zero;
  assign bus.negative  = flags_q.negative;
  assign bus.carry     = flags_q.carry;
  assign bus.overflow  = flags_q.overflow;
  assign bus.illegal   = illegal_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign a      = bus.operand_a;
  assign b      = bus.operand_b;
  assign shamt  = b[SHW-1:0];
  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign dif_w  = {1'b0, a} - {1'b0, b};

`ifdef ALU_MULDIV_EN
  logic             md_done;
  logic [WIDTH-1:0] md_result;

  assign long_op = is_muldiv(bus.op);

  alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (accept & long_op),
    .op     (bus.op),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );
`else
  assign long_op = 1'b0;
`endif

  // Single-cycle datapath; anything it does not decode falls to the illegal default.
  always_comb begin
    simple_res = '0;
    simple_c   = 1'b0;
    simple_v   = 1'b0;
    simple_ill = 1'b0;
    case (bus.op)
      OP_ADD: begin
        simple_res = sum_w[WIDTH-1:0];
        simple_c   = sum_w[WIDTH];
        simple_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        simple_res = dif_w[WIDTH-1:0];
        simple_c   = dif_w[WIDTH];
        simple_v   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  simple_res = a & b;
      OP_OR:   simple_res = a | b;
      OP_XOR:  simple_res = a ^ b;
      OP_SLT:  simple_res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: simple_res = WIDTH'(a < b);
      OP_LUI:  simple_res = {b[HALF-1:0], {HALF{1'b0}}};
      OP_SLL:  simple_res = a << shamt;
      OP_SRL:  simple_res = a >> shamt;
      OP_SRA:  simple_res = $unsigned($signed(a) >>> shamt);
      default: simple_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    illegal_d = illegal_q;

    if (accept) begin
      if (long_op) begin
        state_d = ST_BUSY;
      end else begin
        state_d   = ST_DONE;
        result_d  = simple_res;
        flags_d   = '{zero: (simple_res == '0), negative: simple_res[WIDTH-1],
                      carry: simple_c, overflow: simple_v};
        illegal_d = simple_ill;
      end
    end else if ((state_q == ST_DONE) && bus.out_ready) begin
      state_d = ST_IDLE;
    end

`ifdef ALU_MULDIV_EN
    if ((state_q == ST_BUSY) && md_done) begin
      state_d   = ST_DONE;
      result_d  = md_result;
      flags_d   = '{zero: (md_result == '0), negative: md_result[WIDTH-1],
                    carry: 1'b0, overflow: 1'b0};
      illegal_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed table, random ops vs. model, handshake corners.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  alu_seq_if #(.WIDTH(WIDTH)) bus ();

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flags;   // {zero, negative, carry, overflow}
    logic        ill;
    int          lat;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    exp_t        e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk_exp(input logic [15:0] res, input logic [3:0] flags,
                                  input logic ill, input int lat);
    exp_t e;
    e.res = res; e.flags = flags; e.ill = ill; e.lat = lat;
    return e;
  endfunction

  function automatic vec_t mk_vec(input string name, input logic [3:0] op, input logic [15:0] a,
                                  input logic [15:0] b, input exp_t e);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.e = e;
    return v;
  endfunction

  // Reference model: plain integer arithmetic on the opcode rules.
  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    longint      ua, ub, r;
    int          sa, sb, sr, amt;
    logic        c, v;
    logic [63:0] rb;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    amt = int'(ub % 16);
    r = 0; c = 1'b0; v = 1'b0; e.ill = 1'b0; e.lat = 1;
    case (op)
      4'd0: begin r = ua + ub; c = (r > 65535); sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
      4'd1: begin r = ua - ub; c = (ua < ub);   sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = (sa < sb) ? 1 : 0;
      4'd5: r = (ub % 256) * 256;
      4'd6: r = ua ^ ub;
      4'd7: r = (ua < ub) ? 1 : 0;
      4'd8: r = ua * (longint'(1) << amt);
      4'd9: r = ua / (longint'(1) << amt);
      4'd10: r = sa >>> amt;
`ifdef ALU_MULDIV_EN
      4'd11: begin r = ua * ub;                       e.lat = 17; end
      4'd12: begin r = (ua * ub) / 65536;             e.lat = 17; end
      4'd13: begin r = (ub == 0) ? 65535 : ua / ub;   e.lat = 17; end
      4'd14: begin r = (ub == 0) ? ua : ua % ub;      e.lat = 17; end
`endif
      default: begin r = 0; e.ill = 1'b1; end
    endcase
    rb = r;
    e.res   = rb[15:0];
    e.flags = {(e.res == 16'h0), e.res[15], c, v};
    return e;
  endfunction

  task automatic run_op(input string name, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input exp_t e);
    int n;
    int ready_bad;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check({name, " in_ready"}, bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.op        = alu_op_e'(op);
    bus.operand_a = a;
    bus.operand_b = b;
    tick();
    // Scramble the inputs: the DUT must have captured them at accept.
    bus.in_valid  = 1'b0;
    bus.op        = alu_op_e'($urandom_range(0, 15));
    bus.operand_a = 16'($urandom);
    bus.operand_b = 16'($urandom);
    n = 1;
    ready_bad = 0;
    while (!bus.out_valid && n < 40) begin
      if (bus.in_ready) ready_bad++;
      tick();
      n++;
    end
    check({name, " latency"}, n, e.lat);
    check({name, " result"}, bus.result, e.res);
    check({name, " flags"}, {bus.zero, bus.negative, bus.carry, bus.overflow}, e.flags);
    check({name, " illegal"}, bus.illegal, e.ill);
    if (e.lat > 1) check({name, " in_ready busy"}, ready_bad, 0);
  endtask

  vec_t vecs[$];

  initial begin
    int miss;
    logic [15:0] ta, tb_b;

    vecs.push_back(mk_vec("add_ovf", 4'd0,  16'h7FFF, 16'h0001, mk_exp(16'h8000, 4'b0101, 0, 1)));
    vecs.push_back(mk_vec("sub_brw", 4'd1,  16'h0003, 16'h0005, mk_exp(16'hFFFE, 4'b0110, 0, 1)));
    vecs.push_back(mk_vec("slt",     4'd4,  16'hFFFF, 16'h0001, mk_exp(16'h0001, 4'b0000, 0, 1)));
    vecs.push_back(mk_vec("sltu",    4'd7,  16'hFFFF, 16'h0001, mk_exp(16'h0000, 4'b1000, 0, 1)));
    vecs.push_back(mk_vec("lui",     4'd5,  16'h1234, 16'h00AB, mk_exp(16'hAB00, 4'b0100, 0, 1)));
    vecs.push_back(mk_vec("sra",     4'd10, 16'h8000, 16'h0013, mk_exp(16'hF000, 4'b0100, 0, 1)));
    vecs.push_back(mk_vec("sll",     4'd8,  16'h0001, 16'h000F, mk_exp(16'h8000, 4'b0100, 0, 1)));
    vecs.push_back(mk_vec("srl",     4'd9,  16'h8000, 16'h00F4, mk_exp(16'h0800, 4'b0000, 0, 1)));
    vecs.push_back(mk_vec("and",     4'd2,  16'hF0F0, 16'h0FF0, mk_exp(16'h00F0, 4'b0000, 0, 1)));
    vecs.push_back(mk_vec("or",      4'd3,  16'h00F0, 16'h0F00, mk_exp(16'h0FF0, 4'b0000, 0, 1)));
    vecs.push_back(mk_vec("xor",     4'd6,  16'hAAAA, 16'hAAAA, mk_exp(16'h0000, 4'b1000, 0, 1)));
    vecs.push_back(mk_vec("add_cry", 4'd0,  16'hFFFF, 16'h0001, mk_exp(16'h0000, 4'b1010, 0, 1)));
    vecs.push_back(mk_vec("sub_ovf", 4'd1,  16'h8000, 16'h0001, mk_exp(16'h7FFF, 4'b0001, 0, 1)));
    vecs.push_back(mk_vec("rsvd",    4'd15, 16'h1234, 16'h5678, mk_exp(16'h0000, 4'b1000, 1, 1)));
`ifdef ALU_MULDIV_EN
    vecs.push_back(mk_vec("mul",     4'd11, 16'h0123, 16'h0045, mk_exp(16'h4E6F, 4'b0000, 0, 17)));
    vecs.push_back(mk_vec("mulhu",   4'd12, 16'hFFFF, 16'hFFFF, mk_exp(16'hFFFE, 4'b0100, 0, 17)));
    vecs.push_back(mk_vec("divu",    4'd13, 16'd100,  16'd7,    mk_exp(16'h000E, 4'b0000, 0, 17)));
    vecs.push_back(mk_vec("remu",    4'd14, 16'd100,  16'd7,    mk_exp(16'h0002, 4'b0000, 0, 17)));
    vecs.push_back(mk_vec("divu0",   4'd13, 16'h1234, 16'h0000, mk_exp(16'hFFFF, 4'b0100, 0, 17)));
    vecs.push_back(mk_vec("remu0",   4'd14, 16'h1234, 16'h0000, mk_exp(16'h1234, 4'b0000, 0, 17)));
`else
    vecs.push_back(mk_vec("mul_ill", 4'd11, 16'h0123, 16'h0045, mk_exp(16'h0000, 4'b1000, 1, 1)));
    vecs.push_back(mk_vec("divu_ill",4'd13, 16'd100,  16'd7,    mk_exp(16'h0000, 4'b1000, 1, 1)));
`endif

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = OP_ADD;
    bus.operand_a = '0;
    bus.operand_b = '0;
    reset = 1'b1;
    repeat (3) tick();
    check("rst out_valid", bus.out_valid, 0);
    check("rst result", bus.result, 0);
    check("rst flags", {bus.zero, bus.negative, bus.carry, bus.overflow}, 0);
    check("rst illegal", bus.illegal, 0);
    reset = 1'b0;
    tick();
    check("rst in_ready", bus.in_ready, 1);

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);

    for (int i = 0; i < 150; i++) begin
      logic [3:0]  rop;
      logic [15:0] ra, rb;
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      run_op("rand", rop, ra, rb, model(rop, ra, rb));
    end

    // Back-to-back ADDs: one result per cycle with out_ready held high.
    for (int k = 0; k < 10; k++) begin
      ta   = 16'(k * 16'h0111);
      tb_b = 16'(16'h0100 + k);
      check("tp in_ready", bus.in_ready, 1);
      bus.in_valid  = 1'b1;
      bus.op        = OP_ADD;
      bus.operand_a = ta;
      bus.operand_b = tb_b;
      tick();
      check("tp out_valid", bus.out_valid, 1);
      check("tp result", bus.result, 16'(ta + tb_b));
    end
    bus.in_valid = 1'b0;
    tick();
    check("tp drain", bus.out_valid, 0);

    // Backpressure: result held while out_ready is low, new request stalled.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = OP_ADD;
    bus.operand_a = 16'h1111;
    bus.operand_b = 16'h2222;
    tick();
    bus.in_valid  = 1'b1;
    bus.op        = OP_SUB;
    bus.operand_a = 16'h0005;
    bus.operand_b = 16'h0005;
    check("bp out_valid", bus.out_valid, 1);
    miss = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (!bus.out_valid || bus.result !== 16'h3333 || bus.in_ready) miss++;
    end
    check("bp hold", miss, 0);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("bp next result", bus.result, 16'h0000);
    check("bp next zero", bus.zero, 1);
    tick();
    check("bp idle", bus.out_valid, 0);

    // Reset while a DIVU is in flight (or parked in DONE without muldiv) discards it.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op        = OP_DIVU;
    bus.operand_a = 16'd1000;
    bus.operand_b = 16'd3;
    tick();
    bus.in_valid = 1'b0;
`ifdef ALU_MULDIV_EN
    repeat (3) tick();
    check("rst busy in_ready", bus.in_ready, 0);
`endif
    reset = 1'b1;
    tick();
    check("mid rst out_valid", bus.out_valid, 0);
    check("mid rst result", bus.result, 0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    miss = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (bus.out_valid) miss++;
    end
    check("mid rst no result", miss, 0);
    run_op("post_rst", 4'd0, 16'h0102, 16'h0304, mk_exp(16'h0406, 4'b0000, 0, 1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
